// File: rtl/mux_skid_n.sv
// N:1 word selector with a registered head and a 2-entry skid buffer.
// The selected word, its select index and an out-of-range flag are captured
// together on accept. They leave in strict FIFO order through a valid/ready
// handshake. in_ready_o depends only on state, so there is no combinational
// path from out_ready_i to in_ready_o.
module mux_skid_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N*WIDTH-1:0] d_i,
    input  logic [SW-1:0]      s_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               flush_i,
    output logic [WIDTH-1:0]   y_o,
    output logic [SW-1:0]      y_sel_o,
    output logic               sel_err_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [SW-1:0]    head_sel_q, head_sel_d;
    logic             head_err_q, head_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SW-1:0]    skid_sel_q, skid_sel_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;

    // Word select; out-of-range indices match no input and leave zero.
    always_comb begin
        cap_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (s_i == SW'(i)) begin
                cap_data = d_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign cap_err = (32'(s_i) >= N);
    assign accept  = in_valid_i & in_ready_o;
    assign pop     = out_valid_o & out_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !pop) begin
                        state_d = StTwo;
                    end else if (!accept && pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo:   if (pop) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Output decode from state only.
    always_comb begin
        out_valid_o = (state_q != StEmpty);
        in_ready_o  = (state_q != StTwo) & ~rst_i;
        y_o         = head_data_q;
        y_sel_o     = head_sel_q;
        sel_err_o   = head_err_q;
    end

    // Next head/skid contents; head only changes on fill, replace or skid promotion.
    always_comb begin
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
        if (flush_i) begin
            head_data_d = '0;
            head_sel_d  = '0;
            head_err_d  = 1'b0;
            skid_data_d = '0;
            skid_sel_d  = '0;
            skid_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_data_d = cap_data;
                        head_sel_d  = s_i;
                        head_err_d  = cap_err;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        head_data_d = cap_data;
                        head_sel_d  = s_i;
                        head_err_d  = cap_err;
                    end else if (accept) begin
                        skid_data_d = cap_data;
                        skid_sel_d  = s_i;
                        skid_err_d  = cap_err;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_data_d = skid_data_q;
                        head_sel_d  = skid_sel_q;
                        head_err_d  = skid_err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head and skid storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_data_q <= '0;
            head_sel_q  <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_mux_skid_n.sv
// Bench for mux_skid_n: an N=4 and an N=3 instance share stimulus.
// A negedge monitor keeps one expected-entry queue per instance. It checks
// handshake flags, pop contents and output stability under stall, alongside
// directed sequences.
module tb_mux_skid_n;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [4*W-1:0]   d;
    logic [1:0]       s;

    logic [W-1:0] y4, y3;
    logic [1:0]   ysel4, ysel3;
    logic         err4, err3, ov4, ov3, ir4, ir3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_skid_n #(.WIDTH(W), .N(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .d_i(d), .s_i(s), .in_valid_i(in_valid),
        .in_ready_o(ir4), .flush_i(flush), .y_o(y4), .y_sel_o(ysel4),
        .sel_err_o(err4), .out_valid_o(ov4), .out_ready_i(out_ready)
    );

    mux_skid_n #(.WIDTH(W), .N(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .d_i(d[3*W-1:0]), .s_i(s), .in_valid_i(in_valid),
        .in_ready_o(ir3), .flush_i(flush), .y_o(y3), .y_sel_o(ysel3),
        .sel_err_o(err3), .out_valid_o(ov3), .out_ready_i(out_ready)
    );

    typedef struct packed {
        logic [W-1:0] w;
        logic [1:0]   sel;
        logic         err;
    } sb_t;

    sb_t q4[$];
    sb_t q3[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sb_t model(input int unsigned n, input logic [4*W-1:0] dd,
                                  input logic [1:0] ss);
        sb_t         e;
        int unsigned k;
        k     = 32'(ss);
        e.sel = ss;
        e.err = (k >= n);
        e.w   = e.err ? '0 : dd[k*W +: W];
        return e;
    endfunction

    // Scoreboard monitor; inputs change just after posedge, so negedge
    // values are exactly what the next posedge will sample.
    logic         stall_prev = 1'b0;
    logic [W-1:0] yp4, yp3;
    logic [1:0]   sp4, sp3;
    logic         ep4, ep3;

    always @(negedge clk) begin
        sb_t e;
        logic exp_ready;
        exp_ready = !rst && (q4.size() < 2);
        check("in_ready4", 64'(ir4), 64'(exp_ready));
        check("in_ready3", 64'(ir3), 64'(exp_ready));
        check("out_valid4", 64'(ov4), 64'(q4.size() != 0));
        check("out_valid3", 64'(ov3), 64'(q3.size() != 0));
        if (stall_prev) begin
            check("stable_y4", {31'd0, ep4, sp4, y4 ^ yp4}, {31'd0, err4, ysel4, 32'd0});
            check("stable_y3", {31'd0, ep3, sp3, y3 ^ yp3}, {31'd0, err3, ysel3, 32'd0});
        end
        if (ov4 && out_ready && q4.size() != 0) begin
            e = q4.pop_front();
            check("pop4", {29'd0, err4, ysel4, y4}, {29'd0, e.err, e.sel, e.w});
        end
        if (ov3 && out_ready && q3.size() != 0) begin
            e = q3.pop_front();
            check("pop3", {29'd0, err3, ysel3, y3}, {29'd0, e.err, e.sel, e.w});
        end
        if (rst || flush) begin
            q4.delete();
            q3.delete();
        end else if (in_valid && exp_ready) begin
            q4.push_back(model(4, d, s));
            q3.push_back(model(3, d, s));
        end
        stall_prev = ov4 && !out_ready && !rst && !flush;
        yp4 = y4; sp4 = ysel4; ep4 = err4;
        yp3 = y3; sp3 = ysel3; ep3 = err3;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]   s;
        logic [W-1:0] y4;
        logic         e4;
        logic [W-1:0] y3;
        logic         e3;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 32'h1111_1111, 1'b0, 32'h1111_1111, 1'b0};
        vecs[1] = '{2'd1, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0};
        vecs[2] = '{2'd2, 32'h3333_3333, 1'b0, 32'h3333_3333, 1'b0};
        vecs[3] = '{2'd3, 32'h4444_4444, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{2'd1, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0};
        vecs[5] = '{2'd3, 32'h4444_4444, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6] = '{2'd0, 32'h1111_1111, 1'b0, 32'h1111_1111, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0;
        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // Reset held two cycles, then release.
        tick(2);
        check("rst_out_valid", 64'(ov4), 64'd0);
        check("rst_y", 64'(y4), 64'd0);
        check("rst_in_ready", 64'(ir4), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 64'(ir4), 64'd1);

        // Streaming through the table, one accept per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            s = vecs[i].s;
            tick(1);
            check("vec_valid", 64'(ov4), 64'd1);
            check("vec_y4", {31'd0, err4, ysel4, y4}, {31'd0, vecs[i].e4, vecs[i].s, vecs[i].y4});
            check("vec_y3", {31'd0, err3, ysel3, y3}, {31'd0, vecs[i].e3, vecs[i].s, vecs[i].y3});
        end
        in_valid = 1'b0;
        tick(1);
        check("stream_drained", 64'(ov4), 64'd0);

        // Backpressure: A then B with out_ready low.
        out_ready = 1'b0;
        s = 2'd0;
        in_valid = 1'b1;
        d[W-1:0] = 32'hAAAA_0001;
        tick(1);
        d[W-1:0] = 32'hBBBB_0002;
        tick(1);
        in_valid = 1'b0;
        check("bp_full_ready", 64'(ir4), 64'd0);
        check("bp_head_a", 64'(y4), 64'hAAAA_0001);
        tick(2);
        check("bp_hold_a", 64'(y4), 64'hAAAA_0001);
        out_ready = 1'b1;
        #1;
        check("bp_ready_not_comb", 64'(ir4), 64'd0);
        tick(1);
        check("bp_head_b", 64'(y4), 64'hBBBB_0002);
        check("bp_ready_back", 64'(ir4), 64'd1);
        tick(1);
        check("bp_empty", 64'(ov4), 64'd0);

        // Flush while full with an offer pending.
        out_ready = 1'b0;
        in_valid = 1'b1;
        d[W-1:0] = 32'hCCCC_0003;
        tick(1);
        d[W-1:0] = 32'hDDDD_0004;
        tick(1);
        d[W-1:0] = 32'hEEEE_0005;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(ov4), 64'd0);
        check("flush_ready", 64'(ir4), 64'd1);
        check("flush_y_zero", 64'(y4), 64'd0);

        // Flush in ONE drops the concurrent accept.
        in_valid = 1'b1;
        d[W-1:0] = 32'hF0F0_0006;
        tick(1);
        d[W-1:0] = 32'h6060_0007;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1_valid", 64'(ov4), 64'd0);
        tick(1);
        check("flush1_dropped", 64'(ov4), 64'd0);

        // Reset mid-transfer.
        in_valid = 1'b1;
        tick(2);
        in_valid = 1'b0;
        rst = 1'b1;
        tick(1);
        check("rst_mid_valid", 64'(ov4), 64'd0);
        check("rst_mid_ready", 64'(ir4), 64'd0);
        rst = 1'b0;
        tick(1);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 127) == 0);
            s         = 2'($urandom_range(0, 3));
            d         = {$urandom, $urandom, $urandom, $urandom};
            tick(1);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        tick(4);
        check("drain_q4", 64'(q4.size()), 64'd0);
        check("drain_q3", 64'(q3.size()), 64'd0);
        check("drain_valid", 64'(ov4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
